// File: rtl/block_result_reader_pkg.sv
// Shared types and constants for the result reader: capture FSM states and 7-segment patterns.
// Purely declarative; no timing or flow control.
package block_result_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    CAPT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Common-cathode a..g on bits 0..6, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/block_result_reader_hex_to_7seg.sv
// Nibble to common-cathode 7-segment decoder.
// Combinational, zero latency; no flow control.
module hex_to_7seg
  import block_result_reader_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_seg(nib);

endmodule

// File: rtl/fifo.sv
// Generic synchronous FIFO; head is visible combinationally whenever non-empty.
// Write to read is 1 cycle. A push when full is taken only alongside a pop; a pop when empty is ignored.
module fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop_vld && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/block_result_reader.sv
// Captures one processing-block result per proc episode into a FIFO, popped by a push-button, head shown on seg_out.
// Result at head 2 cycles after proc=0/rdy=1 is sampled; seg_out 1 cycle later; full drops pushes (sticky overflow). RESULT_READER_HEX_EN selects hex decode vs raw.
module block_result_reader
  import block_result_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       res_in,
  input  logic                   proc,
  input  logic                   rdy,
  input  logic                   pop_btn,
  output logic [6:0]             seg_out,
  output logic                   valid,
  output logic                   full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  state_t           state;
  state_t           next_state;
  logic             cap_en;
  logic [WIDTH-1:0] cap_dat;
  logic             push_vld;
  logic [1:0]       pop_sync;
  logic             pop_prev;
  logic             pop_vld;
  logic [WIDTH-1:0] head_dat;
  logic             empty;
  logic [6:0]       seg_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cap_dat <= '0;
    end else begin
      state <= next_state;
      if (cap_en) cap_dat <= res_in;
    end
  end

  // A BUSY episode ending without rdy is an aborted operation and pushes nothing.
  always_comb begin
    next_state = state;
    cap_en     = 1'b0;
    push_vld   = 1'b0;
    case (state)
      IDLE: if (proc) next_state = BUSY;
      BUSY: begin
        if (!proc) begin
          if (rdy) begin
            next_state = CAPT;
            cap_en     = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      CAPT: begin
        push_vld   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_sync <= 2'b00;
      pop_prev <= 1'b0;
    end else begin
      pop_sync <= {pop_sync[0], pop_btn};
      pop_prev <= pop_sync[1];
    end
  end

  assign pop_vld = pop_sync[1] && !pop_prev;

  fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (cap_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  assign valid = !empty;

  // full implies non-empty, so any pop request here is a real pop.
  always_ff @(posedge clk) begin
    if (rst)                                  overflow <= 1'b0;
    else if (push_vld && full && !pop_vld)    overflow <= 1'b1;
  end

`ifdef RESULT_READER_HEX_EN
  hex_to_7seg u_hex (
    .nib (4'(head_dat)),
    .seg (seg_dec)
  );
`else
  assign seg_dec = 7'(head_dat);
`endif

  always_ff @(posedge clk) begin
    if (rst)        seg_out <= SEG_BLANK;
    else if (valid) seg_out <= seg_dec;
    else            seg_out <= SEG_BLANK;
  end

endmodule

// File: tb/tb_block_result_reader.sv
// Directed bench for block_result_reader: capture, abort, full/overflow, pop edge detect, simultaneous push/pop, reset.
// Inputs driven 1ns after the rising edge, outputs sampled at the same point.
module tb_block_result_reader;

  logic       clk;
  logic       rst;
  logic [3:0] res_in;
  logic       proc;
  logic       rdy;
  logic       pop_btn;
  logic [6:0] seg_out;
  logic       valid;
  logic       full;
  logic       overflow;
  logic [2:0] count;

  int checks;
  int errors;

  block_result_reader #(.DEPTH(4), .WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .res_in   (res_in),
    .proc     (proc),
    .rdy      (rdy),
    .pop_btn  (pop_btn),
    .seg_out  (seg_out),
    .valid    (valid),
    .full     (full),
    .overflow (overflow),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [3:0] v);
`ifdef RESULT_READER_HEX_EN
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
`else
    return {3'b000, v};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One proc episode ending with rdy=1; returns after seg_out has had time to follow.
  task automatic capture(input logic [3:0] v);
    proc = 1'b1;
    tick(3);
    proc   = 1'b0;
    rdy    = 1'b1;
    res_in = v;
    tick(2);
    rdy = 1'b0;
    tick(1);
  endtask

  task automatic press(input int hold);
    pop_btn = 1'b1;
    tick(hold);
    pop_btn = 1'b0;
    tick(4);
  endtask

  // Pop edge lands in the same cycle as the CAPT push.
  task automatic capture_with_pop(input logic [3:0] v);
    proc = 1'b1;
    tick(3);
    pop_btn = 1'b1;
    tick(1);
    proc   = 1'b0;
    rdy    = 1'b1;
    res_in = v;
    tick(2);
    rdy     = 1'b0;
    pop_btn = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    res_in  = 4'h0;
    proc    = 1'b0;
    rdy     = 1'b0;
    pop_btn = 1'b0;
    do_reset();
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_seg", 32'(seg_out), 0);

    // 1: single capture, then rdy lingering must not re-capture
    capture(4'h5);
    check("t1_valid", 32'(valid), 1);
    check("t1_count", 32'(count), 1);
    check("t1_seg", 32'(seg_out), 32'(exp_seg(4'h5)));
    rdy = 1'b1;
    tick(4);
    rdy = 1'b0;
    check("t1_rdy_hold_count", 32'(count), 1);
    press(4);
    check("t1_pop_count", 32'(count), 0);
    check("t1_pop_seg", 32'(seg_out), 0);

    // 2: aborted operation
    proc = 1'b1;
    tick(2);
    proc = 1'b0;
    tick(3);
    check("t2_count", 32'(count), 0);
    check("t2_valid", 32'(valid), 0);
    check("t2_seg", 32'(seg_out), 0);

    // 3: fill, overflow, pops, long hold
    capture(4'h1);
    capture(4'h2);
    capture(4'h3);
    capture(4'h4);
    check("t3_full", 32'(full), 1);
    check("t3_count4", 32'(count), 4);
    check("t3_ovf0", 32'(overflow), 0);
    capture(4'h9);
    check("t3_ovf1", 32'(overflow), 1);
    check("t3_count_sat", 32'(count), 4);
    check("t3_head1", 32'(seg_out), 32'(exp_seg(4'h1)));
    press(4);
    press(4);
    check("t3_count2", 32'(count), 2);
    check("t3_head3", 32'(seg_out), 32'(exp_seg(4'h3)));
    press(25);
    check("t3_hold_count", 32'(count), 1);
    check("t3_hold_head4", 32'(seg_out), 32'(exp_seg(4'h4)));
    check("t3_not_full", 32'(full), 0);
    check("t3_ovf_sticky", 32'(overflow), 1);
    do_reset();
    check("t3_rst_ovf", 32'(overflow), 0);
    check("t3_rst_count", 32'(count), 0);

    // 4: push and pop together on a full FIFO
    capture(4'h1);
    capture(4'h2);
    capture(4'h3);
    capture(4'h4);
    capture_with_pop(4'h7);
    check("t4_count", 32'(count), 4);
    check("t4_ovf", 32'(overflow), 0);
    check("t4_head2", 32'(seg_out), 32'(exp_seg(4'h2)));
    press(4);
    press(4);
    press(4);
    check("t4_tail_count", 32'(count), 1);
    check("t4_tail7", 32'(seg_out), 32'(exp_seg(4'h7)));

    // 5: pops on empty, then push and pop together on empty
    press(4);
    check("t5_empty_count", 32'(count), 0);
    press(4);
    check("t5_pop_empty_count", 32'(count), 0);
    check("t5_pop_empty_valid", 32'(valid), 0);
    capture_with_pop(4'h6);
    check("t5_pushpop_count", 32'(count), 1);
    check("t5_pushpop_seg", 32'(seg_out), 32'(exp_seg(4'h6)));

    // 6: reset during BUSY discards the episode
    proc = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst    = 1'b0;
    proc   = 1'b0;
    rdy    = 1'b1;
    res_in = 4'h3;
    tick(4);
    rdy = 1'b0;
    check("t6_count", 32'(count), 0);
    check("t6_ovf", 32'(overflow), 0);
    check("t6_valid", 32'(valid), 0);
    check("t6_seg", 32'(seg_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
